// File: rtl/button_events.sv
// Turns a debounced button level into one-cycle press/release/click/double-click/long-press/repeat pulses.
// "release" and "repeat" are SystemVerilog keywords, so those ports are named release_pulse and repeat_pulse.
module button_events #(
  parameter int CW = 26,
  parameter logic [CW-1:0] LONG_TICKS   = CW'(49999999),
  parameter logic [CW-1:0] REPEAT_TICKS = CW'(9999999),
  parameter logic [CW-1:0] DCLICK_TICKS = CW'(14999999)
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic press,
  output logic release_pulse,
  output logic click,
  output logic double_click,
  output logic long_press,
  output logic repeat_pulse,
  output logic held
);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    REPEAT,
    WAIT2
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] count, count_n;
  logic          second, second_n;
  logic          press_n, release_n, click_n, dclick_n, long_n, repeat_n, held_n;

  // A change of in is always tested before the timer match, so an edge wins over a timeout.
  always_comb begin
    state_n   = state;
    count_n   = count;
    second_n  = second;
    press_n   = 1'b0;
    release_n = 1'b0;
    click_n   = 1'b0;
    dclick_n  = 1'b0;
    long_n    = 1'b0;
    repeat_n  = 1'b0;
    case (state)
      IDLE: begin
        if (in) begin
          press_n  = 1'b1;
          count_n  = '0;
          second_n = 1'b0;
          state_n  = PRESSED;
        end
      end
      PRESSED: begin
        if (!in) begin
          release_n = 1'b1;
          count_n   = '0;
          state_n   = second ? IDLE : WAIT2;
        end else if (count == LONG_TICKS) begin
          long_n  = 1'b1;
          count_n = '0;
          state_n = REPEAT;
        end else begin
          count_n = count + CW'(1);
        end
      end
      REPEAT: begin
        if (!in) begin
          release_n = 1'b1;
          count_n   = '0;
          second_n  = 1'b0;
          state_n   = IDLE;
        end else if (count == REPEAT_TICKS) begin
          repeat_n = 1'b1;
          count_n  = '0;
        end else begin
          count_n = count + CW'(1);
        end
      end
      WAIT2: begin
        if (in) begin
          press_n  = 1'b1;
          dclick_n = 1'b1;
          count_n  = '0;
          second_n = 1'b1;
          state_n  = PRESSED;
        end else if (count == DCLICK_TICKS) begin
          click_n = 1'b1;
          count_n = '0;
          state_n = IDLE;
        end else begin
          count_n = count + CW'(1);
        end
      end
      default: begin
        count_n  = '0;
        second_n = 1'b0;
        state_n  = IDLE;
      end
    endcase
    held_n = (state_n == PRESSED) || (state_n == REPEAT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      count         <= '0;
      second        <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      click         <= 1'b0;
      double_click  <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
    end else begin
      state         <= state_n;
      count         <= count_n;
      second        <= second_n;
      press         <= press_n;
      release_pulse <= release_n;
      click         <= click_n;
      double_click  <= dclick_n;
      long_press    <= long_n;
      repeat_pulse  <= repeat_n;
      held          <= held_n;
    end
  end

endmodule

// File: doc/button_events.md
Name: button_events

Overview:
- Consumer-side companion to the input debouncer. It takes one clean, debounced button level and turns it into one-cycle event pulses: press, release, single click, double click, long press and auto-repeat.
- Sits between a debouncer output and application logic (menus, counters, mode select), so each consumer no longer needs its own edge and timer logic.
- All outputs are registered. The block introduces no combinational path from in to any output.

Parameters:
- CW, 26, counter width in bits. Must be large enough to hold the largest tick parameter.
- LONG_TICKS, 26'd49999999, hold time before long_press fires (1 s at 50 MHz).
- REPEAT_TICKS, 26'd9999999, auto-repeat period after long_press (200 ms at 50 MHz).
- DCLICK_TICKS, 26'd14999999, window after a release in which a second press counts as a double click (300 ms at 50 MHz).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- in  in  1  debounced button level, 1 = pressed
- press  out  1  one-cycle pulse on each accepted press
- release  out  1  one-cycle pulse on each release
- click  out  1  one-cycle pulse when a single short press completes and the double-click window expires
- double_click  out  1  one-cycle pulse on a second press inside the window
- long_press  out  1  one-cycle pulse when the hold time is reached
- repeat  out  1  one-cycle pulse every REPEAT_TICKS+1 cycles while held after long_press
- held  out  1  level, 1 while state is PRESSED or REPEAT

Behaviour:
- Reset (rst=0), asynchronous: state=IDLE, count=0, second=0, all outputs 0.
- Pulse outputs default to 0 every cycle. Each one is set for exactly one cycle at the edge where its event is decided.
- Terminology: "Edge" means a rising clk edge that samples in.
- IDLE:
  - in=1: press=1, count=0, second=0, go to PRESSED.
  - in=0: no action.
- PRESSED:
  - in=0: release=1, count=0. If second=1, go to IDLE; otherwise go to WAIT2.
  - in=1 and count==LONG_TICKS: long_press=1, count=0, go to REPEAT.
  - Otherwise: count+1.
- REPEAT:
  - in=0: release=1, count=0, second=0, go to IDLE.
  - count==REPEAT_TICKS: repeat=1, count=0.
  - Otherwise: count+1.
- WAIT2:
  - in=1: press=1, double_click=1, count=0, second=1, go to PRESSED.
  - in=0 and count==DCLICK_TICKS: click=1, count=0, go to IDLE.
  - Otherwise: count+1.
- Timing: if a press edge is E0, long_press fires at E0+LONG_TICKS+1, provided in stays 1 throughout. Repeats then fire at +REPEAT_TICKS+1 intervals.
- Timing: if a release edge into WAIT2 is R, click fires at R+DCLICK_TICKS+1.
- Priority on simultaneous events: a change of in always wins over a timer match in the same edge.
  - Release at the long edge: release only, no long_press.
  - Press at the timeout edge: double_click, not click.
- A double-clicked press can still reach long_press and repeat. Its release returns to IDLE with no click, which prevents a triple press from reporting as two double clicks.
- count saturates by construction: it is compared for equality and cleared at the match. It never wraps while CW is sufficient.
- Reset mid-operation: everything is cleared immediately. If in=1 when rst is released, press fires at the first edge, because IDLE samples the level rather than an edge.
- held=1 in PRESSED and REPEAT, 0 otherwise. It is registered with the state.

Test Plan:
All scenarios use LONG_TICKS=10, REPEAT_TICKS=4, DCLICK_TICKS=6, CW=8.
- Short press: in=1 for 3 edges (E0..E2), then 0 at E3 -> press at E0, release at E3, click at E10; no other pulses; held=1 for E0..E2.
- Long hold: in=1 from E0 for 30 edges -> press at E0, long_press at E11, repeat at E16, E21, E26; release on drop; no click.
- Double click: press for 2 edges, release at R, re-press at R+3 -> press and double_click both at R+3; the following release goes to IDLE; no click for 20 edges.
- Boundaries:
  - Hold so that in drops exactly at E11 -> release only, no long_press.
  - Re-press exactly at R+7 -> double_click, no click.
- Reset: assert rst during REPEAT with in=1 -> all outputs 0 immediately; release rst with in=1 -> press at the first edge and held=1.
